// File: rtl/mux_arb.sv
// Packet-locking arbiter that drives the one-hot select of a downstream 2:1 flit mux.
// Optional idle-lock watchdog is built only when MUX_ARB_WATCHDOG_EN is defined.
module mux_arb #(
  parameter int TYPEW    = 2,
  parameter int WDOG_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid_0,
  input  logic [TYPEW-1:0] itype_0,
  input  logic             ivalid_1,
  input  logic [TYPEW-1:0] itype_1,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             prio,
  output logic             proto_err,
  output logic             wdog_to,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(3);

  if (WDOG_CYC < 2 || WDOG_CYC > 255) begin : g_bad_wdog
    $error("mux_arb: WDOG_CYC must be in 2..255");
  end

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             busy_q;
  logic             perr_q, perr_d;
  logic             head_0, head_1, body_0, body_1;
  logic             gnt_0, gnt_1;
  logic             lk_valid;
  logic [TYPEW-1:0] lk_type;

`ifdef MUX_ARB_WATCHDOG_EN
  logic [7:0] cnt_q, cnt_d;
  logic       wto_q, wto_d;
`endif

  assign head_0 = ivalid_0 && (itype_0 == T_HEAD);
  assign head_1 = ivalid_1 && (itype_1 == T_HEAD);
  assign body_0 = ivalid_0 && ((itype_0 == T_DATA) || (itype_0 == T_TAIL));
  assign body_1 = ivalid_1 && ((itype_1 == T_DATA) || (itype_1 == T_TAIL));

  // A head collision goes to the port named by prio; a lone head always wins.
  assign gnt_0 = head_0 && (!head_1 || !prio_q);
  assign gnt_1 = head_1 && (!head_0 ||  prio_q);

  assign lk_valid = (state_q == LOCK1) ? ivalid_1 : ivalid_0;
  assign lk_type  = (state_q == LOCK1) ? itype_1  : itype_0;

  always_comb begin
    sel     = 2'b00;
    state_d = state_q;
    prio_d  = prio_q;
    perr_d  = 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
    cnt_d   = 8'd0;
    wto_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        perr_d = body_0 || body_1;
        if (gnt_0) begin
          sel     = 2'b01;
          state_d = LOCK0;
        end else if (gnt_1) begin
          sel     = 2'b10;
          state_d = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        sel    = (state_q == LOCK0) ? 2'b01 : 2'b10;
        perr_d = lk_valid && (lk_type == T_HEAD);
        if (lk_valid && (lk_type == T_TAIL)) begin
          state_d = IDLE;
          prio_d  = (state_q == LOCK0);
        end
`ifdef MUX_ARB_WATCHDOG_EN
        // Counts consecutive bubbles from the lock owner; any owner flit restarts it.
        if (!lk_valid) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(WDOG_CYC)) begin
            cnt_d   = 8'd0;
            wto_d   = 1'b1;
            state_d = IDLE;
            prio_d  = (state_q == LOCK0);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (rst) sel = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
      cnt_q   <= 8'd0;
      wto_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      busy_q  <= (state_d != IDLE);
      perr_q  <= perr_d;
`ifdef MUX_ARB_WATCHDOG_EN
      cnt_q   <= cnt_d;
      wto_q   <= wto_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign prio      = prio_q;
  assign proto_err = perr_q;
  assign dbg_state = state_q;
`ifdef MUX_ARB_WATCHDOG_EN
  assign wdog_to   = wto_q;
`else
  assign wdog_to   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Randomized and directed bench for mux_arb against a packet-level reference model.
// Watchdog expectations follow MUX_ARB_WATCHDOG_EN when the bench is built with it.
module tb_mux_arb;

  localparam int TYPEW = 2;
  localparam int WDOG  = 16;
  localparam int NONE = 0, HEAD = 1, DATA = 2, TAIL = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ivalid_0, ivalid_1;
  logic [TYPEW-1:0] itype_0, itype_1;
  logic [1:0]       sel;
  logic             busy, prio, proto_err, wdog_to;
  logic [1:0]       dbg_state;

  mux_arb #(.TYPEW(TYPEW), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst(rst),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .sel(sel), .busy(busy), .prio(prio),
    .proto_err(proto_err), .wdog_to(wdog_to), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;

  // Expected {sel[1:0], busy, prio, proto_err, wdog_to}
  logic [5:0] exp_q[$];

  // Reference model: who owns the link, tie winner, pending pulses, owner bubble run.
  int owner;
  bit m_prio, m_perr, m_wto;
  int m_idle;
  bit in_v[2];
  int in_t[2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] model_sel(bit r);
    bit h0, h1;
    if (r) return 2'b00;
    if (owner == 0) return 2'b01;
    if (owner == 1) return 2'b10;
    h0 = in_v[0] && in_t[0] == HEAD;
    h1 = in_v[1] && in_t[1] == HEAD;
    if (h0 && h1) return m_prio ? 2'b10 : 2'b01;
    if (h0) return 2'b01;
    if (h1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    owner = -1; m_prio = 0; m_perr = 0; m_wto = 0; m_idle = 0;
  endtask

  task automatic model_update(bit r);
    bit nperr, nwto;
    logic [1:0] g;
    int x;
    if (r) begin
      model_reset();
      return;
    end
    nperr = 0; nwto = 0;
    if (owner < 0) begin
      for (int i = 0; i < 2; i++)
        if (in_v[i] && (in_t[i] == DATA || in_t[i] == TAIL)) nperr = 1;
      g = model_sel(0);
      if (g == 2'b01) owner = 0;
      else if (g == 2'b10) owner = 1;
      m_idle = 0;
    end else begin
      x = owner;
      if (in_v[x] && in_t[x] == HEAD) nperr = 1;
      if (in_v[x] && in_t[x] == TAIL) begin
        owner = -1; m_prio = (x == 0); m_idle = 0;
      end else if (in_v[x]) begin
        m_idle = 0;
      end else begin
        m_idle++;
`ifdef MUX_ARB_WATCHDOG_EN
        if (m_idle == WDOG) begin
          owner = -1; m_prio = (x == 0); nwto = 1; m_idle = 0;
        end
`endif
      end
    end
    m_perr = nperr;
    m_wto  = nwto;
  endtask

  // driver: one clock cycle of stimulus, checked mid-cycle, model advanced at the edge
  task automatic step(input bit r, input bit v0, input int t0, input bit v1, input int t1);
    logic [5:0] e;
    @(negedge clk);
    rst = r;
    ivalid_0 = v0; itype_0 = TYPEW'(t0);
    ivalid_1 = v1; itype_1 = TYPEW'(t1);
    in_v[0] = v0; in_t[0] = t0;
    in_v[1] = v1; in_t[1] = t1;
    exp_q.push_back({model_sel(r), (owner >= 0), m_prio, m_perr, m_wto});
    #1;
    e = exp_q.pop_front();
    check("sel",       8'(sel),       8'(e[5:4]));
    check("busy",      8'(busy),      8'(e[3]));
    check("prio",      8'(prio),      8'(e[2]));
    check("proto_err", 8'(proto_err), 8'(e[1]));
    check("wdog_to",   8'(wdog_to),   8'(e[0]));
    if (busy === 1'b1) busy_cnt++;
    @(posedge clk);
    model_update(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, NONE, 0, NONE);
  endtask

  initial begin
    rst = 1'b1;
    ivalid_0 = 1'b0; ivalid_1 = 1'b0;
    itype_0 = '0;    itype_1 = '0;
    in_v[0] = 0; in_v[1] = 0; in_t[0] = 0; in_t[1] = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, NONE, 0, NONE);
    step(1, 1, HEAD, 1, HEAD);

    // Port 1 long packet alone
    busy_cnt = 0;
    step(0, 0, NONE, 1, HEAD);
    for (int i = 0; i < 20; i++) step(0, 0, NONE, 1, DATA);
    step(0, 0, NONE, 1, TAIL);
    idle(2);
    check("long_pkt_busy_cycles", 8'(busy_cnt), 8'd21);
    check("long_pkt_final_prio", 8'(prio), 8'd0);

    // Simultaneous heads after reset
    step(1, 0, NONE, 0, NONE);
    step(0, 1, HEAD, 1, HEAD);
    for (int i = 0; i < 3; i++) step(0, 1, DATA, 1, HEAD);
    step(0, 1, TAIL, 1, HEAD);
    step(0, 0, NONE, 1, HEAD);
    step(0, 0, NONE, 1, DATA);
    step(0, 0, NONE, 1, DATA);
    step(0, 0, NONE, 1, TAIL);
    idle(1);
    check("tie_final_prio", 8'(prio), 8'd0);

    // Tail on 0 meets head on 1
    step(0, 1, HEAD, 0, NONE);
    step(0, 1, DATA, 1, NONE);
    step(0, 1, TAIL, 1, HEAD);
    step(0, 0, NONE, 1, HEAD);
    step(0, 0, NONE, 1, TAIL);
    // Back-to-back packets from port 0
    step(0, 1, HEAD, 0, NONE);
    step(0, 1, TAIL, 0, NONE);
    step(0, 1, HEAD, 0, NONE);
    step(0, 1, HEAD, 0, NONE);
    step(0, 1, TAIL, 0, NONE);
    idle(1);

    // Protocol errors in IDLE and LOCK, NONE flits ignored
    step(0, 1, DATA, 0, NONE);
    idle(2);
    step(0, 0, NONE, 1, TAIL);
    step(0, 1, NONE, 1, NONE);
    step(0, 1, HEAD, 0, NONE);
    step(0, 1, NONE, 1, DATA);
    step(0, 1, TAIL, 0, NONE);
    idle(2);

    // Reset during port-1 packet
    step(0, 0, NONE, 1, HEAD);
    for (int i = 0; i < 4; i++) step(0, 0, NONE, 1, DATA);
    step(1, 0, NONE, 1, DATA);
    step(0, 0, NONE, 1, DATA);
    idle(2);

    // Owner goes silent: watchdog release or indefinite hold
    step(0, 1, HEAD, 0, NONE);
    for (int i = 0; i < WDOG + 4; i++) step(0, 0, NONE, 1, DATA);
    step(0, 1, TAIL, 0, NONE);
    idle(2);
    step(0, 0, NONE, 1, HEAD);
    for (int i = 0; i < WDOG - 1; i++) step(0, 0, NONE, 0, NONE);
    step(0, 0, NONE, 1, DATA);
    for (int i = 0; i < WDOG + 2; i++) step(0, 0, NONE, 0, NONE);
    step(0, 0, NONE, 1, TAIL);
    idle(2);

    // Randomized traffic, with occasional silent stretches and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < WDOG + 2; k++) step(0, 0, NONE, 0, NONE);
      end else begin
        step(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)));
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
